counter_sweep_ctrl: RTL and testbench
=====================================

// Module: counter_sweep_ctrl
// PURPOSE
//  Upstream controller for the 4-bit up/down counter (en, ud, clk, rst, count).
//  Generates a prescaled enable and the direction so the counter ping-pongs LO..HI..LO.
//  Reads the counter's count back to decide when to reverse; count never leaves [LO,HI].
//  Provides start/halt control, a busy flag, a direction-flip pulse and a sweep tally.
// PARAMETERS
//  WIDTH     4   counter width; width of count_in, LO and HI
//  PRESCALE  10  clk cycles per en pulse; legal range 1..255 (1 = en every cycle)
//  LO        0   lower sweep bound; LO < HI
//  HI        15  upper sweep bound; HI <= 2**WIDTH-1
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  start      in   1      level; begin sweep from IDLE or resume from HOLD
//  halt       in   1      level; freeze sweep in HOLD
//  count_in   in   WIDTH  count output of the downstream counter
//  en         out  1      registered counter enable, one-cycle pulse per tick
//  ud         out  1      registered direction to counter (1 = up, 0 = down)
//  busy       out  1      high in SWEEP_UP / SWEEP_DOWN
//  dir_flip   out  1      one-cycle pulse, coincident with the en that reverses direction
//  sweep_cnt  out  8      completed sweeps (DOWN->UP reversals); wraps 255->0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, prescaler=0, en=0, ud=1, busy=0, dir_flip=0, sweep_cnt=0.
//  States: IDLE, SWEEP_UP, SWEEP_DOWN, HOLD.
//   IDLE -> SWEEP_UP when start=1 & halt=0; prescaler cleared to 0.
//   SWEEP_* -> HOLD when halt=1; prescaler frozen; en=0 from the next cycle.
//   HOLD -> saved SWEEP_* when start=1 & halt=0; prescaler resumes from its frozen value.
//   start & halt both high: halt wins in every state.
//  Tick: in SWEEP_*, prescaler counts 0..PRESCALE-1 and wraps. On the terminal value,
//   the next edge registers en=1 (1-cycle latency from terminal value to en).
//  Direction for each en pulse, decided from count_in sampled on the terminal cycle:
//   SWEEP_UP:   count_in <  HI -> ud=1; count_in >= HI -> ud=0, dir_flip=1, go SWEEP_DOWN.
//   SWEEP_DOWN: count_in >  LO -> ud=0; count_in <= LO -> ud=1, dir_flip=1, go SWEEP_UP,
//               sweep_cnt+1 (modulo 256).
//  Out-of-range count_in (above HI or below LO) forces the direction back toward range.
//  ud holds its last value between pulses and in HOLD/IDLE. Counter steps 1 clk after en.
//  PRESCALE=1: en held high continuously in SWEEP_*; reversal rules unchanged.
//  busy is registered and follows the state.
//  rst assertion mid-sweep returns all outputs to reset values immediately.
// STRUCTURE
//  counter_defs.vh: state encodings (2-bit localparams); default WIDTH, LO, HI.
//  Sub-module tick_gen(PRESCALE): prescaler with clr and hold inputs; tick output
//   high on the terminal value.
//  Top level: FSM, direction decision, sweep_cnt.
// TESTING  (bench instantiates counter_4 downstream; PRESCALE=2, LO=0, HI=15)
//  1. rst=0 for 3 cycles, release -> en=0, ud=1, busy=0, sweep_cnt=0; count stays 0.
//  2. start pulse -> busy=1 next cycle; en pulses every 2 clk; count reaches 15;
//     the next en has ud=0 with dir_flip=1; count never shows 0 after 15 on the up leg.
//  3. Full down leg to 0 -> en with ud=1, dir_flip=1, sweep_cnt=1; second sweep -> 2.
//  4. halt at count=7 (up leg) for 10 cycles -> en=0, count frozen at 7; start ->
//     continues up from 7 with ud=1.
//  5. start & halt both high in IDLE -> stays IDLE, busy=0, en=0.
//  6. rst low mid-down leg (count=9) -> outputs reset within same cycle; start -> UP
//     leg from counter's reset value; separate run with LO=3, HI=12: count stays 3..12.

Source files
------------

// File: rtl/counter_sweep_ctrl_pkg.sv
// counter_sweep_ctrl_pkg
//   Shared definitions for the counter sweep controller: default sizing,
//   FSM state encodings and a small state-classification helper.
package counter_sweep_ctrl_pkg;

    localparam int CSC_WIDTH    = 4;
    localparam int CSC_LO       = 0;
    localparam int CSC_HI       = 15;
    localparam int CSC_PRESCALE = 10;

    // Prescaler register width; covers PRESCALE up to 255.
    localparam int PRE_W = 8;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SWEEP_UP   = 2'd1;
    localparam logic [1:0] ST_SWEEP_DOWN = 2'd2;
    localparam logic [1:0] ST_HOLD       = 2'd3;

    function automatic logic is_sweep(input logic [1:0] st);
        return (st == ST_SWEEP_UP) || (st == ST_SWEEP_DOWN);
    endfunction

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// counter_sweep_ctrl_if
//   Control/status bundle between the sweep controller and its environment.
//   master : drives start, halt and the downstream counter value count_in
//   slave  : the controller; drives en, ud, busy, dir_flip, sweep_cnt
interface counter_sweep_ctrl_if #(
    parameter int WIDTH = counter_sweep_ctrl_pkg::CSC_WIDTH
);
    logic             start;
    logic             halt;
    logic [WIDTH-1:0] count_in;
    logic             en;
    logic             ud;
    logic             busy;
    logic             dir_flip;
    logic [7:0]       sweep_cnt;

    modport master (
        output start, halt, count_in,
        input  en, ud, busy, dir_flip, sweep_cnt
    );

    modport slave (
        input  start, halt, count_in,
        output en, ud, busy, dir_flip, sweep_cnt
    );
endinterface

// File: rtl/counter_sweep_ctrl_tick_gen.sv
// counter_sweep_ctrl_tick_gen
//   Wrapping prescaler 0..PRESCALE-1.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear to 0 (dominates hold)
//   hold : freeze the count at its present value
//   tick : high while the count sits on its terminal value
module counter_sweep_ctrl_tick_gen
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int PRESCALE = CSC_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam logic [PRE_W-1:0] TERM    = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (!hold) begin
            pre_d = (pre_q == TERM) ? '0 : pre_q + PRE_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // With PRESCALE=1 the terminal value is 0, so tick stays high.
    assign tick = (pre_q == TERM);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
//   Drives a downstream up/down counter so that it ping-pongs LO..HI..LO.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of counter_sweep_ctrl_if
//         in  start, halt, count_in
//         out en (one-cycle enable per tick), ud (1 = up), busy,
//             dir_flip (pulse with the reversing en), sweep_cnt (DOWN->UP count)
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// ST_IDLE        | waiting for start; prescaler held at 0
// ST_SWEEP_UP    | ticking, counter stepped upward until it reaches HI
// ST_SWEEP_DOWN  | ticking, counter stepped downward until it reaches LO
// ST_HOLD        | frozen; resumes the saved sweep direction on start
module counter_sweep_ctrl
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH    = CSC_WIDTH,
    parameter int PRESCALE = CSC_PRESCALE,
    parameter int LO       = CSC_LO,
    parameter int HI       = CSC_HI
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_sweep_ctrl_if.slave   bus
);

    localparam logic [WIDTH:0] LO_X  = (WIDTH + 1)'(LO);
    localparam logic [WIDTH:0] HI_X  = (WIDTH + 1)'(HI);
    localparam logic [WIDTH:0] ONE_X = (WIDTH + 1)'(1);

    logic [1:0] state_q,     state_d;
    logic       resume_up_q, resume_up_d;
    logic       en_q,        en_d;
    logic       ud_q,        ud_d;
    logic       busy_q,      busy_d;
    logic       dir_flip_q,  dir_flip_d;
    logic [7:0] sweep_cnt_q, sweep_cnt_d;

    logic           tick;
    logic           run;
    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] cnt_proj;

    assign run   = is_sweep(state_q) && !bus.halt;
    assign cnt_x = {1'b0, bus.count_in};

    counter_sweep_ctrl_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_IDLE),
        .hold (!run),
        .tick (tick)
    );

    // The counter steps on the edge that samples en, so an en still in
    // flight has not reached count_in yet. Folding it in keeps back-to-back
    // ticks (PRESCALE=1) from overshooting the bounds.
    always_comb begin
        cnt_proj = cnt_x;
        if (en_q) begin
            if (ud_q) begin
                cnt_proj = cnt_x + ONE_X;
            end else if (cnt_x != '0) begin
                cnt_proj = cnt_x - ONE_X;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        resume_up_d = resume_up_q;
        en_d        = 1'b0;
        ud_d        = ud_q;
        dir_flip_d  = 1'b0;
        sweep_cnt_d = sweep_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.halt) begin
                    state_d = ST_SWEEP_UP;
                end
            end
            ST_SWEEP_UP: begin
                if (bus.halt) begin
                    state_d     = ST_HOLD;
                    resume_up_d = 1'b1;
                end else if (tick) begin
                    en_d = 1'b1;
                    if (cnt_proj >= HI_X) begin
                        ud_d       = 1'b0;
                        dir_flip_d = 1'b1;
                        state_d    = ST_SWEEP_DOWN;
                    end else begin
                        ud_d = 1'b1;
                    end
                end
            end
            ST_SWEEP_DOWN: begin
                if (bus.halt) begin
                    state_d     = ST_HOLD;
                    resume_up_d = 1'b0;
                end else if (tick) begin
                    en_d = 1'b1;
                    if (cnt_proj <= LO_X) begin
                        ud_d        = 1'b1;
                        dir_flip_d  = 1'b1;
                        state_d     = ST_SWEEP_UP;
                        sweep_cnt_d = sweep_cnt_q + 8'd1;
                    end else begin
                        ud_d = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.start && !bus.halt) begin
                    state_d = resume_up_q ? ST_SWEEP_UP : ST_SWEEP_DOWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = is_sweep(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            resume_up_q <= 1'b1;
            en_q        <= 1'b0;
            ud_q        <= 1'b1;
            busy_q      <= 1'b0;
            dir_flip_q  <= 1'b0;
            sweep_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            resume_up_q <= resume_up_d;
            en_q        <= en_d;
            ud_q        <= ud_d;
            busy_q      <= busy_d;
            dir_flip_q  <= dir_flip_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign bus.en        = en_q;
    assign bus.ud        = ud_q;
    assign bus.busy      = busy_q;
    assign bus.dir_flip  = dir_flip_q;
    assign bus.sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Two controllers share start/halt/rst: instance A (PRESCALE=2, 0..15) and
// instance B (PRESCALE=1, 3..12), each driving its own 4-bit up/down counter.
// A position-based reference model predicts every output and counter value.
module tb_counter_sweep_ctrl;

    logic clk;
    logic rst;
    logic start;
    logic halt;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;

    counter_sweep_ctrl_if #(.WIDTH(4)) bus_a ();
    counter_sweep_ctrl_if #(.WIDTH(4)) bus_b ();

    assign bus_a.start    = start;
    assign bus_a.halt     = halt;
    assign bus_a.count_in = cnt_a;
    assign bus_b.start    = start;
    assign bus_b.halt     = halt;
    assign bus_b.count_in = cnt_b;

    counter_sweep_ctrl #(.WIDTH(4), .PRESCALE(2), .LO(0), .HI(15)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );

    counter_sweep_ctrl #(.WIDTH(4), .PRESCALE(1), .LO(3), .HI(12)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // downstream counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_a <= 4'd0;
            cnt_b <= 4'd0;
        end else begin
            if (bus_a.en) cnt_a <= bus_a.ud ? cnt_a + 4'd1 : cnt_a - 4'd1;
            if (bus_b.en) cnt_b <= bus_b.ud ? cnt_b + 4'd1 : cnt_b - 4'd1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model, index 0 = A, 1 = B
    int P_M  [2] = '{2, 1};
    int LO_M [2] = '{0, 3};
    int HI_M [2] = '{15, 12};

    int m_mode [2];   // 0 idle, 1 sweeping, 2 held
    bit m_up   [2];
    int m_phase[2];   // running cycles since sweep start, modulo PRESCALE
    int m_pos  [2];   // counter position once every issued en has landed
    int m_cnt  [2];   // counter value as seen now
    bit e_en   [2];
    bit e_ud   [2];
    bit e_flip [2];
    bit e_busy [2];
    int e_sweeps[2];
    bit seen_lo_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]   = 0;
            m_up[i]     = 1'b1;
            m_phase[i]  = 0;
            m_pos[i]    = 0;
            m_cnt[i]    = 0;
            e_en[i]     = 1'b0;
            e_ud[i]     = 1'b1;
            e_flip[i]   = 1'b0;
            e_busy[i]   = 1'b0;
            e_sweeps[i] = 0;
        end
        seen_lo_b = 1'b0;
    endtask

    // advance the model across one clock edge with the given inputs
    task automatic model_next(input bit st, input bit hl);
        for (int i = 0; i < 2; i++) begin
            if (e_en[i]) m_cnt[i] = (m_cnt[i] + (e_ud[i] ? 1 : 15)) % 16;
            e_en[i]   = 1'b0;
            e_flip[i] = 1'b0;
            if (m_mode[i] == 0) begin
                if (st && !hl) begin
                    m_mode[i]  = 1;
                    m_up[i]    = 1'b1;
                    m_phase[i] = 0;
                end
            end else if (m_mode[i] == 1) begin
                if (hl) begin
                    m_mode[i] = 2;
                end else begin
                    if (m_phase[i] == P_M[i] - 1) begin
                        e_en[i] = 1'b1;
                        if (m_up[i] && m_pos[i] >= HI_M[i]) begin
                            m_up[i]   = 1'b0;
                            e_flip[i] = 1'b1;
                        end else if (!m_up[i] && m_pos[i] <= LO_M[i]) begin
                            m_up[i]     = 1'b1;
                            e_flip[i]   = 1'b1;
                            e_sweeps[i] = (e_sweeps[i] + 1) % 256;
                        end
                        e_ud[i]  = m_up[i];
                        m_pos[i] = m_pos[i] + (m_up[i] ? 1 : -1);
                    end
                    m_phase[i] = (m_phase[i] + 1) % P_M[i];
                end
            end else begin
                if (st && !hl) m_mode[i] = 1;
            end
            e_busy[i] = (m_mode[i] == 1);
        end
    endtask

    task automatic chk_all();
        chk("a_en",        bus_a.en,        e_en[0]);
        chk("a_ud",        bus_a.ud,        e_ud[0]);
        chk("a_busy",      bus_a.busy,      e_busy[0]);
        chk("a_dir_flip",  bus_a.dir_flip,  e_flip[0]);
        chk("a_sweep_cnt", bus_a.sweep_cnt, e_sweeps[0]);
        chk("a_count",     cnt_a,           m_cnt[0]);
        chk("b_en",        bus_b.en,        e_en[1]);
        chk("b_ud",        bus_b.ud,        e_ud[1]);
        chk("b_busy",      bus_b.busy,      e_busy[1]);
        chk("b_dir_flip",  bus_b.dir_flip,  e_flip[1]);
        chk("b_sweep_cnt", bus_b.sweep_cnt, e_sweeps[1]);
        chk("b_count",     cnt_b,           m_cnt[1]);
        if (seen_lo_b) chk("b_in_range", (cnt_b >= 4'd3 && cnt_b <= 4'd12), 1);
        if (m_cnt[1] == 3) seen_lo_b = 1'b1;
    endtask

    // one clock: inputs change on the falling edge, outputs checked 1 after the rise
    task automatic step(input bit st, input bit hl, input bit rs);
        @(negedge clk);
        start = st;
        halt  = hl;
        if (!rs) begin
            rst = 1'b0;
            model_reset();
            #1;
            chk_all();
            @(posedge clk);
            #1;
            chk_all();
        end else begin
            rst = 1'b1;
            model_next(st, hl);
            @(posedge clk);
            #1;
            chk_all();
        end
    endtask

    initial begin
        int budget;
        start = 1'b0;
        halt  = 1'b0;
        rst   = 1'b1;
        model_reset();
        #2 rst = 1'b0;

        // reset held for 3 cycles, then released
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);

        // start pulse, run two full sweeps on A
        step(1, 0, 1);
        chk("start_busy", bus_a.busy, 1);
        budget = 0;
        while (e_sweeps[0] != 2 && budget < 300) begin
            step(0, 0, 1);
            budget++;
        end
        chk("two_sweeps_in_time", budget < 300, 1);
        chk("sweep_cnt_two", bus_a.sweep_cnt, 2);

        // halt at count 7 on the up leg
        budget = 0;
        while (!(m_cnt[0] == 7 && m_up[0] && !e_en[0] && m_mode[0] == 1) && budget < 200) begin
            step(0, 0, 1);
            budget++;
        end
        chk("reach_7_up", budget < 200, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 1);
        chk("hold_count", cnt_a, 7);
        chk("hold_en", bus_a.en, 0);
        chk("hold_busy", bus_a.busy, 0);
        step(1, 0, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 1);

        // reset mid down leg at count 9
        budget = 0;
        while (!(m_cnt[0] == 9 && !m_up[0] && !e_en[0] && m_mode[0] == 1) && budget < 200) begin
            step(0, 0, 1);
            budget++;
        end
        chk("reach_9_down", budget < 200, 1);
        step(0, 0, 0);
        chk("rst_ud", bus_a.ud, 1);
        step(0, 0, 0);
        step(0, 0, 1);

        // start and halt together in IDLE
        for (int i = 0; i < 5; i++) step(1, 1, 1);
        chk("idle_both_busy", bus_a.busy, 0);
        chk("idle_both_en", bus_a.en, 0);
        step(0, 0, 1);

        // restart from the counter's reset value
        step(1, 0, 1);
        for (int i = 0; i < 70; i++) step(0, 0, 1);

        // randomized start/halt/reset
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 199) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
